// File: rtl/ext_int_pkg.sv
// Shared constants for the external interrupt controller: register word offsets,
// interrupt ID width and the bus response state encoding.
package ext_int_pkg;

    localparam int ID_WIDTH = 5;

    // Word offsets within the 64-byte window, taken from bus_addr[5:2]
    localparam logic [3:0] REG_PENDING   = 4'h0;
    localparam logic [3:0] REG_ENABLE    = 4'h1;
    localparam logic [3:0] REG_THRESHOLD = 4'h2;
    localparam logic [3:0] REG_CLAIM     = 4'h3;
    localparam logic [3:0] REG_PRIO_BASE = 4'h4;

    typedef enum logic {
        BUS_IDLE,
        BUS_RESP
    } bus_state_e;

    // Source index addressed by a PRIORITY word offset; negative below the priority block.
    function automatic int prio_index(input logic [3:0] word);
        return int'(word) - int'(REG_PRIO_BASE);
    endfunction

endpackage

// File: rtl/int_prio_select.sv
// Combinational priority reduction: picks the highest-priority eligible source,
// lowest index on ties, and reports its ID (0 when nothing is eligible).
module int_prio_select
    import ext_int_pkg::*;
#(
    parameter int Sources   = 8,
    parameter int PrioWidth = 3
) (
    input  logic [Sources-1:0]                pending,
    input  logic [Sources-1:0]                enable,
    input  logic [Sources-1:0][PrioWidth-1:0] prio,
    input  logic [PrioWidth-1:0]              threshold,
    output logic [ID_WIDTH-1:0]               best_id,
    output logic                              any_eligible
);

    logic [PrioWidth-1:0] best_prio;

    // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
    always_comb begin
        best_id      = '0;
        best_prio    = '0;
        any_eligible = 1'b0;
        for (int i = 0; i < Sources; i++) begin
            if (pending[i] && enable[i] && (prio[i] > threshold)) begin
                // Strict compare keeps the earlier (lower) index on equal priority
                if (!any_eligible || (prio[i] > best_prio)) begin
                    best_prio = prio[i];
                    best_id   = ID_WIDTH'(i + 1);
                end
                any_eligible = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ext_int_ctl.sv
// External interrupt controller: synchronises level requests, gates them into pending bits,
// and serves enable/threshold/priority/claim registers on the arilla bus; drives exti.
module ext_int_ctl
    import ext_int_pkg::*;
#(
    parameter int          Sources     = 8,
    parameter int          PrioWidth   = 3,
    parameter logic [31:0] BaseAddress = 32'h0000_F000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [Sources-1:0] irq_src,
    input  logic [31:0]        bus_addr,
    input  logic [31:0]        bus_wdata,
    input  logic               bus_rd,
    input  logic               bus_wr,
    output logic [31:0]        bus_rdata,
    output logic               bus_complete,
    output logic               exti
);

    logic [Sources-1:0]                sync_meta;
    logic [Sources-1:0]                sync_level;
    logic [Sources-1:0]                pending;
    logic [Sources-1:0]                enable;
    logic [Sources-1:0]                gate_open;
    logic [Sources-1:0]                gate_set;
    logic [Sources-1:0]                claim_clr;
    logic [Sources-1:0]                reopen;
    logic [PrioWidth-1:0]              threshold;
    logic [Sources-1:0][PrioWidth-1:0] prio;

    logic [ID_WIDTH-1:0] best_id;
    logic                any_eligible;

    logic                in_window;
    logic                acc_rd;
    logic                acc_wr;
    logic [3:0]          word;
    logic                claim_rd;
    logic                complete_wr;
    logic [ID_WIDTH-1:0] complete_id;
    logic [31:0]         read_data;
    logic [31:0]         rdata_q;

    bus_state_e state;
    bus_state_e state_next;

    logic unused_bits;

    // ---------------------------------------------------------------- bus decode
    assign in_window   = (bus_addr[31:6] == BaseAddress[31:6]);
    assign acc_wr      = in_window & bus_wr;
    assign acc_rd      = in_window & bus_rd & ~bus_wr;  // a write on the same cycle wins
    assign word        = bus_addr[5:2];
    assign claim_rd    = acc_rd & (word == REG_CLAIM);
    assign complete_wr = acc_wr & (word == REG_CLAIM);
    assign complete_id = bus_wdata[ID_WIDTH-1:0];
    assign unused_bits = ^{bus_addr[1:0], bus_wdata};

    // ---------------------------------------------------------------- synchroniser
    // NOTE: non-blocking assignments let sync_level take the old sync_meta, giving two true flop stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta  <= '0;
            sync_level <= '0;
        end else begin
            sync_meta  <= irq_src;
            sync_level <= sync_meta;
        end
    end

    // ---------------------------------------------------------------- gateways and pending
    assign gate_set = gate_open & sync_level;

    always_comb begin
        claim_clr = '0;
        reopen    = '0;
        for (int i = 0; i < Sources; i++) begin
            claim_clr[i] = claim_rd && (best_id == ID_WIDTH'(i + 1));
            reopen[i]    = complete_wr && !gate_open[i] && (complete_id == ID_WIDTH'(i + 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            gate_open <= '1;
        end else begin
            pending   <= (pending & ~claim_clr) | gate_set;
            gate_open <= (gate_open & ~gate_set) | reopen;
        end
    end

    // ---------------------------------------------------------------- configuration registers
    // NOTE: the priority table is a bank of flops, not a RAM, so it takes the async reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= '0;
            threshold <= '0;
            prio      <= '0;
        end else if (acc_wr) begin
            if (word == REG_ENABLE) begin
                enable <= bus_wdata[Sources-1:0];
            end
            if (word == REG_THRESHOLD) begin
                threshold <= bus_wdata[PrioWidth-1:0];
            end
            for (int i = 0; i < Sources; i++) begin
                if (prio_index(word) == i) begin
                    prio[i] <= bus_wdata[PrioWidth-1:0];
                end
            end
        end
    end

    int_prio_select #(
        .Sources   (Sources),
        .PrioWidth (PrioWidth)
    ) u_prio_select (
        .pending      (pending),
        .enable       (enable),
        .prio         (prio),
        .threshold    (threshold),
        .best_id      (best_id),
        .any_eligible (any_eligible)
    );

    // ---------------------------------------------------------------- read mux
    always_comb begin
        read_data = '0;
        case (word)
            REG_PENDING:   read_data[Sources-1:0]   = pending;
            REG_ENABLE:    read_data[Sources-1:0]   = enable;
            REG_THRESHOLD: read_data[PrioWidth-1:0] = threshold;
            REG_CLAIM:     read_data[ID_WIDTH-1:0]  = best_id;
            default: begin
                for (int i = 0; i < Sources; i++) begin
                    if (prio_index(word) == i) begin
                        read_data[PrioWidth-1:0] = prio[i];
                    end
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- bus response FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = BUS_IDLE;
        if (acc_rd || acc_wr) begin
            state_next = BUS_RESP;
        end
    end

    always_comb begin
        bus_complete = (state == BUS_RESP);
    end

    // Read data is captured with the strobe so a claim reports the pre-clear best_id
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= acc_rd ? read_data : '0;
        end
    end

    assign bus_rdata = rdata_q;

    // ---------------------------------------------------------------- interrupt output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exti <= 1'b0;
        end else begin
            exti <= any_eligible;
        end
    end

endmodule

// File: tb/tb_ext_int_ctl.sv
// Directed self-checking bench for ext_int_ctl: reset, gateway timing, claim/complete,
// priority/threshold arbitration, window decode and same-edge interactions.
module tb_ext_int_ctl;

    localparam logic [31:0] BASE      = 32'h0000_F000;
    localparam logic [31:0] A_PENDING = BASE + 32'h00;
    localparam logic [31:0] A_ENABLE  = BASE + 32'h04;
    localparam logic [31:0] A_THRESH  = BASE + 32'h08;
    localparam logic [31:0] A_CLAIM   = BASE + 32'h0C;

    logic        clk;
    logic        rst_n;
    logic [7:0]  irq_src;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_rd;
    logic        bus_wr;
    logic [31:0] bus_rdata;
    logic        bus_complete;
    logic        exti;

    int checks = 0;
    int errors = 0;

    ext_int_ctl #(
        .Sources     (8),
        .PrioWidth   (3),
        .BaseAddress (BASE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rd       (bus_rd),
        .bus_wr       (bus_wr),
        .bus_rdata    (bus_rdata),
        .bus_complete (bus_complete),
        .exti         (exti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] prio_addr(input int idx);
        return BASE + 32'h10 + 32'(4 * idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // All bus tasks start and end on a falling edge; the strobe is sampled at the rising edge between.
    task automatic bus_access(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic exp_ack, input string tag,
                              output logic [31:0] data);
        bus_rd    = rd;
        bus_wr    = wr;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(negedge clk);
        check({tag, "_ack"}, 32'(bus_complete), 32'(exp_ack));
        data      = bus_rdata;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [31:0] data, input string tag,
                             input logic exp_ack = 1'b1);
        logic [31:0] dummy;
        bus_access(1'b0, 1'b1, addr, data, exp_ack, tag, dummy);
    endtask

    task automatic read_check(input logic [31:0] addr, input logic [31:0] expected, input string tag,
                              input logic exp_ack = 1'b1);
        logic [31:0] data;
        bus_access(1'b1, 1'b0, addr, 32'h0, exp_ack, tag, data);
        check(tag, data, expected);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] data;
        rst_n     = 1'b0;
        irq_src   = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;

        // ---- reset, then reset asserted in the middle of an ENABLE write
        wait_neg(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_exti", 32'(exti), 32'h0);
        check("rst_complete", 32'(bus_complete), 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        bus_wr    = 1'b1;
        bus_addr  = A_ENABLE;
        bus_wdata = 32'hFF;
        #2 rst_n = 1'b0;
        @(negedge clk);
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        check("midrst_complete", 32'(bus_complete), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_complete", 32'(bus_complete), 32'h0);
        check("post_rst_exti", 32'(exti), 32'h0);
        read_check(A_ENABLE, 32'h0, "rst_enable");
        read_check(A_THRESH, 32'h0, "rst_threshold");
        read_check(A_PENDING, 32'h0, "rst_pending");
        read_check(prio_addr(2), 32'h0, "rst_prio2");

        // ---- single source: latency, claim, gateway hold-off, complete
        write_reg(prio_addr(2), 32'h5, "wr_prio2");
        write_reg(A_ENABLE, 32'h04, "wr_enable_b2");
        irq_src[2] = 1'b1;
        wait_neg(3);
        check("lat_exti_early", 32'(exti), 32'h0);
        wait_neg(1);
        check("lat_exti_4cyc", 32'(exti), 32'h1);
        read_check(A_CLAIM, 32'd3, "claim_src3");
        check("exti_at_claim", 32'(exti), 32'h1);
        wait_neg(1);
        check("exti_after_claim", 32'(exti), 32'h0);
        read_check(A_PENDING, 32'h0, "pend_after_claim");
        wait_neg(5);
        read_check(A_PENDING, 32'h0, "no_repend_closed");
        check("exti_stays_low", 32'(exti), 32'h0);
        write_reg(A_CLAIM, 32'd3, "complete3");
        wait_neg(2);
        check("exti_repend", 32'(exti), 32'h1);
        read_check(A_PENDING, 32'h04, "pend_after_complete");
        irq_src[2] = 1'b0;
        wait_neg(3);
        read_check(A_CLAIM, 32'd3, "claim_src3_again");
        write_reg(A_CLAIM, 32'd3, "complete3_again");

        // ---- tie on equal priority, then the higher priority wins
        write_reg(prio_addr(1), 32'h3, "wr_prio1");
        write_reg(prio_addr(4), 32'h3, "wr_prio4");
        write_reg(A_ENABLE, 32'h12, "wr_enable_b1b4");
        irq_src[1] = 1'b1;
        irq_src[4] = 1'b1;
        wait_neg(4);
        check("tie_exti", 32'(exti), 32'h1);
        read_check(A_CLAIM, 32'd2, "claim_tie");
        write_reg(A_CLAIM, 32'd2, "complete2");
        write_reg(prio_addr(4), 32'h6, "wr_prio4_6");
        read_check(A_CLAIM, 32'd5, "claim_higher");
        read_check(A_CLAIM, 32'd2, "claim_remaining");
        read_check(A_PENDING, 32'h0, "pend_after_pair");
        read_check(prio_addr(4), 32'h6, "rd_prio4");
        irq_src[1] = 1'b0;
        irq_src[4] = 1'b0;
        wait_neg(3);
        write_reg(A_CLAIM, 32'd2, "complete2_b");
        write_reg(A_CLAIM, 32'd5, "complete5");

        // ---- threshold gating, then same-edge claim and new pend
        write_reg(A_ENABLE, 32'h01, "wr_enable_b0");
        write_reg(prio_addr(0), 32'h5, "wr_prio0");
        write_reg(A_THRESH, 32'h5, "wr_thresh5");
        irq_src[0] = 1'b1;
        wait_neg(5);
        check("thresh_blocks", 32'(exti), 32'h0);
        read_check(A_PENDING, 32'h01, "pend_below_thresh");
        write_reg(A_THRESH, 32'h4, "wr_thresh4");
        check("thresh_exti_same", 32'(exti), 32'h0);
        wait_neg(1);
        check("thresh_exti_next", 32'(exti), 32'h1);
        irq_src[2] = 1'b1;
        wait_neg(2);
        read_check(A_CLAIM, 32'd1, "claim_same_edge");
        read_check(A_PENDING, 32'h04, "pend_same_edge");
        read_check(A_THRESH, 32'h4, "rd_thresh");
        irq_src[0] = 1'b0;
        irq_src[2] = 1'b0;
        wait_neg(3);
        write_reg(A_CLAIM, 32'd1, "complete1");
        read_check(A_CLAIM, 32'd0, "claim_disabled_src");
        write_reg(A_ENABLE, 32'h04, "wr_enable_b2_again");
        read_check(A_CLAIM, 32'd3, "claim_src3_c");
        write_reg(A_CLAIM, 32'd3, "complete3_c");

        // ---- nothing eligible, and ignored completes
        write_reg(A_ENABLE, 32'h00, "wr_enable_none");
        irq_src[6] = 1'b1;
        wait_neg(4);
        read_check(A_CLAIM, 32'd0, "claim_none");
        read_check(A_PENDING, 32'h40, "pend_untouched");
        check("exti_none", 32'(exti), 32'h0);
        write_reg(A_ENABLE, 32'h40, "wr_enable_b6");
        write_reg(prio_addr(6), 32'h7, "wr_prio6");
        read_check(A_CLAIM, 32'd7, "claim_src7");
        read_check(A_PENDING, 32'h0, "pend_src7_claimed");
        write_reg(A_CLAIM, 32'd0, "complete0");
        write_reg(A_CLAIM, 32'd31, "complete31");
        write_reg(A_CLAIM, 32'd8, "complete_open");
        wait_neg(3);
        read_check(A_PENDING, 32'h0, "pend_ignored_completes");
        check("exti_ignored_completes", 32'(exti), 32'h0);
        write_reg(A_CLAIM, 32'd7, "complete7");
        wait_neg(2);
        read_check(A_PENDING, 32'h40, "pend_src7_repend");

        // ---- read and write together: write wins, no claim
        bus_access(1'b1, 1'b1, A_CLAIM, 32'h0, 1'b1, "rdwr_claim", data);
        check("rdwr_rdata", data, 32'h0);
        read_check(A_PENDING, 32'h40, "pend_after_rdwr");

        // ---- window decode and unmapped offsets
        write_reg(BASE + 32'h44, 32'hFF, "oow_write", 1'b0);
        read_check(BASE + 32'h40, 32'h0, "oow_read", 1'b0);
        read_check(A_ENABLE, 32'h40, "enable_untouched");
        read_check(BASE + 32'h3C, 32'h0, "unmapped_read");
        write_reg(prio_addr(7), 32'hFFFF_FFFF, "wr_prio7");
        read_check(prio_addr(7), 32'h7, "rd_prio7");
        read_check(prio_addr(7) + 32'h2, 32'h7, "rd_prio7_byte_off");

        irq_src[6] = 1'b0;
        wait_neg(3);
        read_check(A_CLAIM, 32'd7, "claim_src7_final");
        write_reg(A_CLAIM, 32'd7, "complete7_final");
        wait_neg(3);
        check("final_exti", 32'(exti), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
